// File: rtl/univ_shift_register.sv
// -----------------------------------------------------------------------------
// univ_shift_register
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load on a WIDTH-bit word, with serial in/out at both ends.
// Counts the shifts since the last load (saturating at WIDTH) and flags when
// the loaded word has been completely shifted out.
//
// Build option:
//   UNIV_SR_ROTATE_EN - when defined, both shift modes become rotates and the
//                       serial inputs ser_in_r / ser_in_l are ignored.
//                       drained then means one full rotation is complete.
// -----------------------------------------------------------------------------
module univ_shift_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] d_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             drained
);

    // Mode encodings
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Saturation value of the shift counter
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    // State registers
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_cnt;
    logic             r_drained;

    // Next-state wires
    logic [WIDTH-1:0] w_data_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_drained_nxt;

    // Bits entering the word at each end on a shift
    logic             w_fill_msb;
    logic             w_fill_lsb;

    // Saturating counter value and drain detection for a shift this cycle
    logic [CW-1:0]    w_cnt_inc;
    logic             w_cnt_hits_full;

`ifdef UNIV_SR_ROTATE_EN
    // Rotate: the bit leaving one end re-enters at the other end
    assign w_fill_msb = r_data[0];
    assign w_fill_lsb = r_data[WIDTH-1];

    // Serial inputs have no function in rotate builds
    logic w_unused_ser;
    assign w_unused_ser = ser_in_r ^ ser_in_l;
`else
    // Shift: external serial bits fill the vacated position
    assign w_fill_msb = ser_in_r;
    assign w_fill_lsb = ser_in_l;
`endif

    // Saturating increment of the shift count
    always_comb begin
        w_cnt_inc       = r_cnt;
        w_cnt_hits_full = 1'b0;
        if (r_cnt >= CNT_FULL) begin
            w_cnt_inc       = CNT_FULL;
            w_cnt_hits_full = 1'b1;
        end else begin
            w_cnt_inc       = r_cnt + {{(CW-1){1'b0}}, 1'b1};
            w_cnt_hits_full = ((r_cnt + {{(CW-1){1'b0}}, 1'b1}) == CNT_FULL);
        end
    end

    // Next-state decode of the register word, shift count and drain flag
    always_comb begin
        w_data_nxt    = r_data;
        w_cnt_nxt     = r_cnt;
        w_drained_nxt = r_drained;
        case (mode)
            MODE_HOLD: begin
                w_data_nxt    = r_data;
                w_cnt_nxt     = r_cnt;
                w_drained_nxt = r_drained;
            end
            MODE_SHR: begin
                w_data_nxt    = {w_fill_msb, r_data[WIDTH-1:1]};
                w_cnt_nxt     = w_cnt_inc;
                // Once drained, the flag stays up until the next load
                w_drained_nxt = r_drained | w_cnt_hits_full;
            end
            MODE_SHL: begin
                w_data_nxt    = {r_data[WIDTH-2:0], w_fill_lsb};
                w_cnt_nxt     = w_cnt_inc;
                w_drained_nxt = r_drained | w_cnt_hits_full;
            end
            MODE_LOAD: begin
                // A load always wins, even on a drained register
                w_data_nxt    = d_in;
                w_cnt_nxt     = {CW{1'b0}};
                w_drained_nxt = 1'b0;
            end
            default: begin
                w_data_nxt    = r_data;
                w_cnt_nxt     = r_cnt;
                w_drained_nxt = r_drained;
            end
        endcase
    end

    // State update; synchronous reset has priority over every mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= RESET_VAL;
            r_cnt     <= {CW{1'b0}};
            r_drained <= 1'b1;
        end else begin
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drained <= w_drained_nxt;
        end
    end

    // Outputs come straight from flops, so the serial taps are glitch-free
    assign d_out     = r_data;
    assign ser_out_r = r_data[0];
    assign ser_out_l = r_data[WIDTH-1];
    assign shift_cnt = r_cnt;
    assign drained   = r_drained;

endmodule

// File: tb/tb_univ_shift_register.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_register
// Directed-vector bench for univ_shift_register (WIDTH=4, RESET_VAL=0).
// The rotate scenario is selected when UNIV_SR_ROTATE_EN is defined; the
// default build checks the equivalent serial-input behaviour instead.
// -----------------------------------------------------------------------------
module tb_univ_shift_register;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic [W-1:0]  d_in;
    logic          ser_in_r;
    logic          ser_in_l;
    logic [W-1:0]  d_out;
    logic          ser_out_r;
    logic          ser_out_l;
    logic [CW-1:0] shift_cnt;
    logic          drained;

    int checks_cnt;
    int fail_cnt;

    univ_shift_register #(
        .WIDTH     (W),
        .RESET_VAL (4'b0000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .d_in      (d_in),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .d_out     (d_out),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
        .drained   (drained)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic r, input logic [1:0] m, input logic [W-1:0] d,
                        input logic sr, input logic sl);
        rst      = r;
        mode     = m;
        d_in     = d;
        ser_in_r = sr;
        ser_in_l = sl;
        @(posedge clk);
        #1;
    endtask

    // Compare full visible state
    task automatic check_state(input string tag, input logic [W-1:0] exp_d,
                               input logic [CW-1:0] exp_c, input logic exp_dr);
        check_eq({tag, "_d"},   64'(d_out),     64'(exp_d));
        check_eq({tag, "_cnt"}, 64'(shift_cnt), 64'(exp_c));
        check_eq({tag, "_dr"},  64'(drained),   64'(exp_dr));
    endtask

    logic [W-1:0] exp_shr [4];
    logic         exp_sor [4];
    logic [W-1:0] exp_shl [4];
    logic         exp_sol [4];

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b0; mode = 2'b00; d_in = 4'b0000; ser_in_r = 1'b0; ser_in_l = 1'b0;
        @(negedge clk);

        // 1: reset wins over a load request for two cycles
        step(1'b1, 2'b11, 4'b1111, 1'b0, 1'b0);
        check_state("rst1", 4'b0000, 3'd0, 1'b1);
        step(1'b1, 2'b11, 4'b1111, 1'b0, 1'b0);
        check_state("rst2", 4'b0000, 3'd0, 1'b1);

        // 2: load 1010, four right shifts with ser_in_r=0, then one more
        exp_shr = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
        exp_sor = '{1'b0, 1'b1, 1'b0, 1'b1};
        step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
        check_state("ld1010", 4'b1010, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("shr_sor%0d", i), 64'(ser_out_r), 64'(exp_sor[i]));
            step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b0);
            check_state($sformatf("shr%0d", i), exp_shr[i], 3'(i + 1), (i == 3));
        end
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b0);
        check_state("shr_sat", 4'b0000, 3'd4, 1'b1);

        // 3: load 1100, four left shifts with ser_in_l=1
        exp_shl = '{4'b1001, 4'b0011, 4'b0111, 4'b1111};
        exp_sol = '{1'b1, 1'b1, 1'b0, 1'b0};
        step(1'b0, 2'b11, 4'b1100, 1'b0, 1'b0);
        check_state("ld1100", 4'b1100, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("shl_sol%0d", i), 64'(ser_out_l), 64'(exp_sol[i]));
            step(1'b0, 2'b10, 4'b0000, 1'b0, 1'b1);
            check_state($sformatf("shl%0d", i), exp_shl[i], 3'(i + 1), (i == 3));
        end

        // 4: load 0110, hold three cycles, reload 1111
        step(1'b0, 2'b11, 4'b0110, 1'b1, 1'b1);
        check_state("ld0110", 4'b0110, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 4'b1001, 1'b1, 1'b1);
            check_state($sformatf("hold%0d", i), 4'b0110, 3'd0, 1'b0);
        end
        step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0);
        check_state("ld1111", 4'b1111, 3'd0, 1'b0);

        // 5: reset in the middle of a shift sequence
        step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b0);
        check_state("mid_shr1", 4'b0101, 3'd1, 1'b0);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b0);
        check_state("mid_shr2", 4'b0010, 3'd2, 1'b0);
        step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1);
        check_state("mid_rst", 4'b0000, 3'd0, 1'b1);
        step(1'b0, 2'b01, 4'b0000, 1'b1, 1'b0);
        check_eq("post_rst_d",   64'(d_out),     64'(4'b1000));
        check_eq("post_rst_cnt", 64'(shift_cnt), 64'(3'd1));

        // Mixed directions: every shift counts once
        step(1'b0, 2'b11, 4'b1001, 1'b0, 1'b0);
        step(1'b0, 2'b01, 4'b0000, 1'b1, 1'b0);
        check_state("mix1", 4'b1100, 3'd1, 1'b0);
        step(1'b0, 2'b10, 4'b0000, 1'b1, 1'b0);
        check_state("mix2", 4'b1000, 3'd2, 1'b0);
        step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b1);
        check_state("mix3", 4'b0100, 3'd3, 1'b0);
        step(1'b0, 2'b10, 4'b0000, 1'b0, 1'b1);
        check_state("mix4", 4'b1001, 3'd4, 1'b1);

        // 6: four right shifts with ser_in_r=1 then one left with ser_in_l=0
        step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
`ifdef UNIV_SR_ROTATE_EN
        exp_shr = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
`else
        exp_shr = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b01, 4'b0000, 1'b1, 1'b0);
            check_state($sformatf("r6_%0d", i), exp_shr[i], 3'(i + 1), (i == 3));
        end
        step(1'b0, 2'b10, 4'b0000, 1'b1, 1'b0);
`ifdef UNIV_SR_ROTATE_EN
        check_state("r6_left", 4'b0101, 3'd4, 1'b1);
`else
        check_state("r6_left", 4'b1110, 3'd4, 1'b1);
`endif
        check_eq("r6_sol", 64'(ser_out_l), 64'(d_out[W-1]));
        check_eq("r6_sor", 64'(ser_out_r), 64'(d_out[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised universal shift register; the successor to the team's fixed 4-bit parallel-load register. Supports hold, parallel load, shift right and shift left on a WIDTH-bit word with serial in/out at both ends. Tracks the number of shifts since the last load and flags when the loaded word has been fully shifted out. Serves as the common storage and serialiser element for datapath and serial-link blocks.

Parameters:
WIDTH, 4, register width in bits; legal range 2 to 64.
RESET_VAL, {WIDTH{1'b0}}, value loaded into d_out on reset.
CW, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
d_in  input  WIDTH  parallel load data.
ser_in_r  input  1  serial bit entering the MSB on a right shift.
ser_in_l  input  1  serial bit entering the LSB on a left shift.
d_out  output  WIDTH  registered contents.
ser_out_r  output  1  equals d_out[0], the bit leaving on the next right shift.
ser_out_l  output  1  equals d_out[WIDTH-1], the bit leaving on the next left shift.
shift_cnt  output  CW  shifts performed since the last load or reset; saturates at WIDTH.
drained  output  1  high when shift_cnt == WIDTH, or after reset.

Behaviour:
- All state updates on posedge clk. Single-cycle latency: an operation on edge N is visible on d_out after edge N.
- Reset: rst has priority over mode. Reset values: d_out = RESET_VAL, shift_cnt = 0, drained = 1.
- Hold (00): d_out, shift_cnt and drained unchanged.
- Load (11): d_out <= d_in, shift_cnt <= 0, drained <= 0. A load always wins, including when drained = 1.
- Shift right (01): d_out <= {ser_in_r, d_out[WIDTH-1:1]}.
- Shift left (10): d_out <= {d_out[WIDTH-2:0], ser_in_l}.
- Counter, on either shift: shift_cnt <= shift_cnt + 1, saturating at WIDTH. drained <= 1 on the shift that makes shift_cnt reach WIDTH.
- Shifting with drained = 1 is legal: data still shifts, shift_cnt stays at WIDTH, drained stays 1.
- Mixed directions between loads are legal. Each shift counts as one regardless of direction.
- ser_out_r and ser_out_l are combinational taps of d_out. They are glitch-free because they are driven straight from flops.
- Reset asserted mid-sequence discards contents and count on that edge. The first non-reset edge behaves as from the reset state.
- No X propagation: mode is fully decoded and every value of mode is defined.

Optional Feature:
Macro UNIV_SR_ROTATE_EN.
- Defined: the shift modes become rotates. ser_in_r and ser_in_l are ignored.
  - Right: d_out <= {d_out[0], d_out[WIDTH-1:1]}.
  - Left: d_out <= {d_out[WIDTH-2:0], d_out[WIDTH-1]}.
  - shift_cnt and drained behave as in shift mode. drained means one full rotation is complete.
- Undefined: shifts use the serial inputs as specified in Behaviour. The serial inputs are functional.

Test Plan (WIDTH=4, RESET_VAL=0, macro undefined unless stated):
1. Assert rst for 2 cycles with mode=11 and d_in=1111 -> d_out=0000, shift_cnt=0, drained=1; the load is ignored.
2. Load 1010, then 4 right shifts with ser_in_r=0 -> d_out goes 0101, 0010, 0001, 0000; ser_out_r goes 0, 1, 0, 1 before each shift; shift_cnt goes 1..4; drained rises on the 4th shift. A 5th shift leaves shift_cnt=4.
3. Load 1100, then 4 left shifts with ser_in_l=1 -> d_out goes 1001, 0011, 0111, 1111; ser_out_l before each shift is 1, 1, 0, 0.
4. Load 0110, hold 3 cycles, then load 1111 on the next edge -> d_out stays 0110 through the holds; shift_cnt=0 and drained=0 throughout; d_out=1111 after the second load.
5. Load 1010, shift right twice, assert rst on the 3rd cycle with mode=01 -> d_out=0000, shift_cnt=0, drained=1 after the reset edge.
6. With UNIV_SR_ROTATE_EN defined: load 1010, rotate right 4 times with ser_in_r=1 -> d_out goes 0101, 1010, 0101, 1010; drained=1 after the 4th rotate. Then rotate left once -> d_out=0101.
